// File: rtl/msp430_bb_ext_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : msp430_bb_ext_arbiter                                      |
// | Description : Round-robin arbiter/sequencer sharing one external         |
// |               Blackbone memory port among NODES tile request channels.   |
// |               Serialises accesses, pulses a one-hot per-requester ack    |
// |               and returns read data after READ_LATENCY cycles.           |
// | Ports       : clk, rst          - clock, synchronous active-high reset   |
// |               req_en/we/addr/din_i - per-requester request channels      |
// |               req_ack_o         - one-hot completion pulse               |
// |               req_dout_o        - shared read data (valid with ack)      |
// |               mem_en/we/addr/din_o, mem_dout_i - external memory port    |
// |               busy_o            - high whenever not IDLE                 |
// |               grant_id_o        - index of current/most recent grant     |
// | Options     : MSP430_BB_ARB_PRIO0_EN - requester 0 gets fixed top        |
// |               priority; the others round-robin among themselves.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module msp430_bb_ext_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int NODES        = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NODES-1:0]         req_en_i,
  input  logic [NODES-1:0]         req_we_i,
  input  logic [NODES*AW-1:0]      req_addr_i,
  input  logic [NODES*DW-1:0]      req_din_i,
  output logic [NODES-1:0]         req_ack_o,
  output logic [DW-1:0]            req_dout_o,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [DW-1:0]            mem_din_o,
  input  logic [DW-1:0]            mem_dout_i,
  output logic                     busy_o,
  output logic [$clog2(NODES)-1:0] grant_id_o
);

  localparam int IW = $clog2(NODES);
  localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    last_grant_q;
  logic [IW-1:0]    grant_id_q;
  logic [WW-1:0]    wait_cnt_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_din_q;
  logic [NODES-1:0] req_ack_q;
  logic [DW-1:0]    req_dout_q;
  logic             busy_q;

  logic [NODES-1:0] w_rr_req;
  logic [IW-1:0]    w_cand;
  logic [IW-1:0]    w_rr_idx;
  logic [IW-1:0]    w_win_idx;
  logic             w_upd_last;
  logic             w_any;

  // Round-robin search starting at last_grant+1. Candidates are visited
  // from the farthest to the nearest, so the nearest requesting one is the
  // last assignment and wins without needing a "found" flag.
  always_comb begin
    w_rr_req = req_en_i;
`ifdef MSP430_BB_ARB_PRIO0_EN
    w_rr_req[0] = 1'b0;
`endif
    w_rr_idx = '0;
    w_cand   = '0;
    for (int k = NODES; k >= 1; k--) begin
      w_cand = IW'((int'(last_grant_q) + k) % NODES);
      if (w_rr_req[w_cand]) begin
        w_rr_idx = w_cand;
      end
    end
`ifdef MSP430_BB_ARB_PRIO0_EN
    // Requester 0 pre-empts the rotation and does not move the pointer.
    w_win_idx  = req_en_i[0] ? '0 : w_rr_idx;
    w_upd_last = ~req_en_i[0];
`else
    w_win_idx  = w_rr_idx;
    w_upd_last = 1'b1;
`endif
    w_any = |req_en_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NODES - 1);
      grant_id_q   <= '0;
      wait_cnt_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      req_ack_q    <= '0;
      req_dout_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      // Pulsed outputs default low; they are set only on the transition
      // into the state in which they must be visible.
      mem_en_q  <= 1'b0;
      req_ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (w_any) begin
            grant_id_q <= w_win_idx;
            if (w_upd_last) begin
              last_grant_q <= w_win_idx;
            end
            mem_we_q   <= req_we_i[w_win_idx];
            mem_addr_q <= req_addr_i[int'(w_win_idx)*AW +: AW];
            mem_din_q  <= req_din_i[int'(w_win_idx)*DW +: DW];
            mem_en_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_we_q) begin
            req_ack_q[grant_id_q] <= 1'b1;
            state_q               <= ST_ACK;
          end else begin
            wait_cnt_q <= WW'(READ_LATENCY - 1);
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            req_dout_q            <= mem_dout_i;
            req_ack_q[grant_id_q] <= 1'b1;
            state_q               <= ST_ACK;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        ST_ACK: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack_o  = req_ack_q;
  assign req_dout_o = req_dout_q;
  assign mem_en_o   = mem_en_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_din_o  = mem_din_q;
  assign busy_o     = busy_q;
  assign grant_id_o = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_msp430_bb_ext_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_msp430_bb_ext_arbiter                                   |
// | Description : Self-checking bench for msp430_bb_ext_arbiter with a       |
// |               latency-accurate RAM and a transaction-level reference.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_msp430_bb_ext_arbiter;

  localparam int NODES = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int RL    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NODES-1:0]    en;
  logic [NODES-1:0]    we;
  logic [AW-1:0]       addr [NODES];
  logic [DW-1:0]       din  [NODES];
  logic [NODES*AW-1:0] addr_bus;
  logic [NODES*DW-1:0] din_bus;

  logic [NODES-1:0]         req_ack;
  logic [DW-1:0]            req_dout;
  logic                     mem_en;
  logic                     mem_we;
  logic [AW-1:0]            mem_addr;
  logic [DW-1:0]            mem_din;
  logic [DW-1:0]            mem_dout;
  logic                     busy;
  logic [$clog2(NODES)-1:0] grant_id;

  always_comb begin
    addr_bus = '0;
    din_bus  = '0;
    for (int n = 0; n < NODES; n++) begin
      addr_bus[n*AW +: AW] = addr[n];
      din_bus[n*DW +: DW]  = din[n];
    end
  end

  msp430_bb_ext_arbiter #(
    .AW(AW), .DW(DW), .NODES(NODES), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_en_i(en), .req_we_i(we), .req_addr_i(addr_bus), .req_din_i(din_bus),
    .req_ack_o(req_ack), .req_dout_o(req_dout),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_din_o(mem_din), .mem_dout_i(mem_dout),
    .busy_o(busy), .grant_id_o(grant_id)
  );

  // ---------------- external RAM with fixed read latency ----------------
  function automatic logic [DW-1:0] default_f(input logic [AW-1:0] a);
    if (a == 32'h200) return 32'h12345678;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  logic [DW-1:0] ram [1024];
  logic [1023:0] wr_vld;
  logic [DW-1:0] rd_pipe [RL];

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    if (wr_vld[a[9:0]]) return ram[a[9:0]];
    return default_f(a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      wr_vld <= '0;
    end else if (mem_en && mem_we) begin
      ram[mem_addr[9:0]]    <= mem_din;
      wr_vld[mem_addr[9:0]] <= 1'b1;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? ram_rd(mem_addr) : 32'hDEAD0001;
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_dout = rd_pipe[RL-1];

  // ---------------- reference model state ----------------
  int            n_chk = 0;
  int            n_err = 0;
  int            m_last = NODES - 1;
  logic [DW-1:0] exp_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return default_f(a);
  endfunction

  // Winner: first pending requester after the last rotating grant.
  function automatic int model_pick();
`ifdef MSP430_BB_ARB_PRIO0_EN
    if (en[0]) return 0;
`endif
    for (int k = 1; k <= NODES; k++) begin
      int c;
      c = (m_last + k) % NODES;
`ifdef MSP430_BB_ARB_PRIO0_EN
      if (c != 0 && en[c]) return c;
`else
      if (en[c]) return c;
`endif
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy",  64'(busy),     64'(0));
    chk("rst_en",    64'(mem_en),   64'(0));
    chk("rst_we",    64'(mem_we),   64'(0));
    chk("rst_ack",   64'(req_ack),  64'(0));
    chk("rst_addr",  64'(mem_addr), 64'(0));
    chk("rst_din",   64'(mem_din),  64'(0));
    chk("rst_dout",  64'(req_dout), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
  endtask

  task automatic set_req(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    en[n]   = 1'b1;
    we[n]   = w;
    addr[n] = a;
    din[n]  = d;
  endtask

  // Runs one complete access starting from an IDLE cycle with requests
  // pending, checking every cycle of it against the spec timing.
  task automatic serve_one(input bit scramble, output int won);
    int               w;
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;
    logic             wr;
    logic [NODES-1:0] oh;
    w  = model_pick();
    won = w;
    if (w < 0) begin
      chk("no_pending", 64'(0), 64'(1));
      return;
    end
    a = addr[w]; d = din[w]; wr = we[w];
    step();
    chk("issue_en",    64'(mem_en),   64'(1));
    chk("issue_we",    64'(mem_we),   64'(wr));
    chk("issue_addr",  64'(mem_addr), 64'(a));
    chk("issue_din",   64'(mem_din),  64'(d));
    chk("issue_grant", 64'(grant_id), 64'(w));
    chk("issue_busy",  64'(busy),     64'(1));
    chk("issue_ack",   64'(req_ack),  64'(0));
    if (scramble) begin
      addr[w] = AW'($urandom_range(0, 1023));
      din[w]  = $urandom;
      we[w]   = ~we[w];
    end
    repeat (wr ? 0 : RL) begin
      step();
      chk("wait_ack",  64'(req_ack), 64'(0));
      chk("wait_en",   64'(mem_en),  64'(0));
      chk("wait_busy", 64'(busy),    64'(1));
    end
    step();
    oh = NODES'(1) << w;
    chk("ack_onehot", 64'(req_ack), 64'(oh));
    chk("ack_en",     64'(mem_en),  64'(0));
    if (!wr) chk("rdata", 64'(req_dout), 64'(exp_rd(a)));
    en[w] = 1'b0;
    if (wr) exp_mem[a] = d;
`ifdef MSP430_BB_ARB_PRIO0_EN
    if (w != 0) m_last = w;
`else
    m_last = w;
`endif
    step();
    chk("idle_busy", 64'(busy),    64'(0));
    chk("idle_ack",  64'(req_ack), 64'(0));
  endtask

  initial begin
    int won;
    en = '0;
    we = '0;
    for (int n = 0; n < NODES; n++) begin
      addr[n] = '0;
      din[n]  = '0;
    end

    // Reset state
    rst = 1'b1;
    step(); step();
    chk_reset_outputs();
    rst = 1'b0;
    step();
    chk("idle_no_req_en", 64'(mem_en), 64'(0));

    // Single write from requester 3
    set_req(3, 1'b1, 32'h100, 32'hDEADBEEF);
    serve_one(1'b0, won);
    chk("single_wr_id", 64'(won), 64'(3));

    // Single read from requester 5, 0x200 returns 0x12345678
    set_req(5, 1'b0, 32'h200, 32'h0);
    serve_one(1'b0, won);
    chk("single_rd_id", 64'(won), 64'(5));
    step();
    chk("dout_hold", 64'(req_dout), 64'(32'h12345678));

    // Address changed mid-read is ignored
    set_req(1, 1'b1, 32'h10, 32'hCAFEF00D);
    serve_one(1'b0, won);
    set_req(2, 1'b1, 32'h20, 32'h0BADBEEF);
    serve_one(1'b0, won);
    set_req(6, 1'b0, 32'h10, 32'h0);
    serve_one(1'b1, won);
    chk("latched_rd", 64'(req_dout), 64'(32'hCAFEF00D));

    // All requesters write continuously from reset
    rst = 1'b1; en = '0;
    step();
    rst = 1'b0; m_last = NODES - 1; exp_mem.delete();
    for (int n = 0; n < NODES; n++)
      set_req(n, 1'b1, AW'(n * 4 + 32'h300), $urandom);
    for (int g = 0; g <= NODES; g++) begin
      serve_one(1'b0, won);
`ifdef MSP430_BB_ARB_PRIO0_EN
      chk("prio_order", 64'(won), 64'(0));
`else
      chk("rr_order", 64'(won), 64'(g % NODES));
`endif
      set_req(won, 1'b1, AW'($urandom_range(0, 255) * 4), $urandom);
    end
    en = '0;

    // Requesters 0 and 4 held, then 2 and 4 held
    set_req(0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 63) * 4), $urandom);
    set_req(4, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 63) * 4), $urandom);
    repeat (3) begin
      serve_one(1'b0, won);
      set_req(won, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 63) * 4), $urandom);
    end
    en = '0;
    set_req(2, 1'b1, 32'h44, $urandom);
    set_req(4, 1'b0, 32'h44, 32'h0);
    repeat (3) begin
      serve_one(1'b0, won);
      set_req(won, $urandom_range(0, 1) == 1, 32'h44, $urandom);
    end
    en = '0;

    // Reset in the middle of a read's WAIT phase
    set_req(1, 1'b0, 32'h40, 32'h0);
    step();
    chk("abort_issue", 64'(mem_en), 64'(1));
    step();
    chk("abort_wait_busy", 64'(busy), 64'(1));
    rst = 1'b1; en[1] = 1'b0;
    step();
    rst = 1'b0; m_last = NODES - 1; exp_mem.delete();
    chk_reset_outputs();
    set_req(2, 1'b1, 32'h80, 32'h5555AAAA);
    serve_one(1'b0, won);
    chk("post_rst_id", 64'(won), 64'(2));

    // Randomised traffic
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < NODES; n++)
        if (!en[n] && $urandom_range(0, 2) == 0)
          set_req(n, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15) * 4), $urandom);
      if (en == '0) begin
        step();
        chk("rand_idle_en",   64'(mem_en), 64'(0));
        chk("rand_idle_busy", 64'(busy),   64'(0));
      end else begin
        serve_one($urandom_range(0, 1) == 1, won);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msp430_bb_ext_arbiter.md
# msp430_bb_ext_arbiter

Round-robin arbiter and sequencer that shares a single external Blackbone memory port among the per-tile `bb_ext_*` request channels of the MSP430 MPSoC. It sits between the tile array and one synchronous external RAM/peripheral. It serialises accesses, adds a per-requester acknowledge, and returns read data after the RAM's fixed read latency.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `NODES`, 8, number of requesters (≥2).
- `READ_LATENCY`, 1, cycles from `mem_en` to valid `mem_dout` (≥1).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_en`  in  NODES  per-requester access request; held until `req_ack`.
- `req_we`  in  NODES  1 = write, 0 = read.
- `req_addr`  in  NODES×AW  request address.
- `req_din`  in  NODES×DW  write data.
- `req_ack`  out  NODES  one-cycle completion pulse, one-hot.
- `req_dout`  out  DW  read data, shared by all requesters; valid while `req_ack` is high for a read.
- `mem_en`  out  1  external port enable; one-cycle pulse.
- `mem_we`  out  1  external port write enable.
- `mem_addr`  out  AW  external address.
- `mem_din`  out  DW  external write data.
- `mem_dout`  in  DW  external read data.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  $clog2(NODES)  index of the current or most recent grant.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - If any `req_en` is set, select the winner by round-robin, searching from `last_grant+1` with modulo-NODES wrap.
  - Register the winner's `req_we`, `req_addr` and `req_din` into `mem_*`, and the winner's index into `grant_id`/`last_grant`.
  - Go to ISSUE.
- **ISSUE**
  - `mem_en`=1 for exactly this cycle.
  - Write: go to ACK.
  - Read: load `wait_cnt`=READ_LATENCY-1 and go to WAIT.
- **WAIT**
  - At `wait_cnt`=0, register `mem_dout` into `req_dout` and go to ACK.
  - Otherwise decrement `wait_cnt`.
- **ACK**
  - `req_ack[grant_id]`=1 for one cycle, then go to IDLE.
- Requester changes to `req_*` after the grant are ignored; the values latched in IDLE are used.
- A requester must drop `req_en` after sampling `req_ack`. If `req_en` is still high in IDLE, that is a new request and it is arbitrated normally.
- `req_dout` holds its value until the next read capture. It is don't-care for writes.
- Requests are never dropped. With all NODES requesters active, each is served once every NODES grants.

## Timing
- Reset values:
  - state=IDLE.
  - `mem_en`, `mem_we`, `req_ack`, `busy` = 0.
  - `mem_addr`, `mem_din`, `req_dout` = 0.
  - `grant_id` = 0; `last_grant` = NODES-1, so requester 0 wins first.
- Request first seen in IDLE at cycle t:
  - Write: `mem_en` at t+1, `req_ack` at t+2, IDLE at t+3.
  - Read: `mem_en` at t+1, `mem_dout` sampled at t+READ_LATENCY+1, `req_ack`/`req_dout` valid at t+READ_LATENCY+2.
- Throughput:
  - Back-to-back writes: one access per 3 cycles.
  - Back-to-back reads: one access per READ_LATENCY+3 cycles.
- Simultaneous requests in IDLE: exactly one is granted, and the others wait.
- `rst` mid-transaction:
  - Next cycle is IDLE with all outputs at reset values.
  - No `req_ack` is issued for the aborted access.
  - `last_grant` returns to NODES-1.

## Configuration
- `MSP430_BB_ARB_PRIO0_EN`
  - Defined: requester 0 has fixed highest priority. Whenever `req_en[0]` is set in IDLE, requester 0 wins, and `last_grant` is not updated by these grants. Requesters 1..NODES-1 round-robin among themselves.
  - Undefined: pure round-robin over all NODES requesters.

## Test plan
- Single write, NODES=8, READ_LATENCY=1: req 3 writes 0xDEADBEEF to 0x100 at t -> `mem_en`/`mem_we`=1 with that address and data at t+1; `req_ack`=8'b0000_1000 at t+2.
- Single read, READ_LATENCY=3: RAM returns 0x12345678 for 0x200, req 5 reads -> `mem_en` at t+1; `req_ack[5]`=1 and `req_dout`=0x12345678 at t+5.
- All 8 requesters write continuously from reset -> grant order 0,1,…,7,0 (PRIO0 undefined); each `req_ack` spaced 3 cycles apart.
- With `MSP430_BB_ARB_PRIO0_EN` defined, requesters 0 and 4 both held -> requester 0 wins every arbitration; with only 2 and 4 held, they alternate 2,4,2.
- `rst` asserted during WAIT of a read by req 1 -> `req_ack` stays 0; next request from req 2 is issued 2 cycles after `rst` deasserts.
- Requester changes `req_addr` from 0x10 to 0x20 during WAIT -> `mem_addr` stays 0x10 and the data read from 0x10 is returned.
